// File: rtl/row_window.sv
// ============================================================================
// row_window : frame-aware 3-row window stage (prev/cur/next) with zero-padded
//              top and bottom edges and a registered valid/ready output.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module row_window #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_row,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_prev,
  output logic [WIDTH-1:0] out_cur,
  output logic [WIDTH-1:0] out_next,
  output logic             out_first,
  output logic             out_last,
  output logic [IDX_W-1:0] out_row,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    TAIL = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] prev_r;
  logic [WIDTH-1:0] cur_r;
  logic [IDX_W-1:0] cnt;

  logic out_free;
  logic accept;

  assign out_free = !out_valid || out_ready;
  assign in_ready = reset && (state != TAIL) && out_free;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      prev_r    <= '0;
      cur_r     <= '0;
      cnt       <= '0;
      out_prev  <= '0;
      out_cur   <= '0;
      out_next  <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_row   <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      prev_r    <= '0;
      cur_r     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      // A consumed window retires unless a new one is loaded below.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            if (in_last) begin
              out_prev  <= '0;
              out_cur   <= in_row;
              out_next  <= '0;
              out_first <= 1'b1;
              out_last  <= 1'b1;
              out_row   <= '0;
              out_valid <= 1'b1;
            end else begin
              prev_r <= '0;
              cur_r  <= in_row;
              cnt    <= '0;
              state  <= HOLD;
            end
          end
        end
        HOLD: begin
          if (accept) begin
            out_prev  <= prev_r;
            out_cur   <= cur_r;
            out_next  <= in_row;
            out_first <= (cnt == '0);
            out_last  <= 1'b0;
            out_row   <= cnt;
            out_valid <= 1'b1;
            prev_r    <= cur_r;
            cur_r     <= in_row;
            cnt       <= cnt + IDX_W'(1);
            if (in_last) begin
              state <= TAIL;
            end
          end
        end
        TAIL: begin
          // Bottom edge: the last held row becomes centre with zero below.
          if (out_free) begin
            out_prev  <= prev_r;
            out_cur   <= cur_r;
            out_next  <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b1;
            out_row   <= cnt;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_row_window.sv
// ============================================================================
// tb_row_window : scoreboard bench for row_window (WIDTH=8, IDX_W=2).
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_row_window;

  localparam int WIDTH = 8;
  localparam int IDX_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic [WIDTH-1:0] in_row;
  logic             in_last;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_prev;
  logic [WIDTH-1:0] out_cur;
  logic [WIDTH-1:0] out_next;
  logic             out_first;
  logic             out_last;
  logic [IDX_W-1:0] out_row;
  logic             out_valid;
  logic             out_ready;

  always #5 clk = ~clk;

  row_window #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_row    (in_row),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_prev  (out_prev),
    .out_cur   (out_cur),
    .out_next  (out_next),
    .out_first (out_first),
    .out_last  (out_last),
    .out_row   (out_row),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] n;
    logic             f;
    logic             l;
    logic [IDX_W-1:0] r;
  } win_t;

  win_t expq[$];
  win_t mon_act;
  win_t mon_exp;
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] p, input logic [7:0] c, input logic [7:0] n,
                      input logic f, input logic l, input logic [1:0] r);
    expq.push_back({p, c, n, f, l, r});
  endtask

  // Consumption happens on the posedge following a negedge where both are high.
  always @(negedge clk) begin
    if (reset && !flush && out_valid && out_ready) begin
      mon_act = {out_prev, out_cur, out_next, out_first, out_last, out_row};
      if (expq.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_window: got %0h expected none", mon_act);
      end else begin
        mon_exp = expq.pop_front();
        chk("window", 32'(mon_act), 32'(mon_exp));
      end
    end
  end

  task automatic send(input logic [7:0] r, input logic l);
    bit ok;
    ok = 1'b0;
    in_row   = r;
    in_last  = l;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      nvec++;
      nerr++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 for row %0h", r);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    in_row    = '0;
    in_last   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(2);
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 0);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_outputs", 32'({out_prev, out_cur, out_next, out_first, out_last, out_row}), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 32'(in_ready), 1);

    // 3-row frame, free-flowing output
    push(8'h00, 8'h11, 8'h22, 1'b1, 1'b0, 2'd0);
    push(8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 2'd1);
    push(8'h22, 8'h33, 8'h00, 1'b0, 1'b1, 2'd2);
    @(posedge clk); #1;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b1);
    @(negedge clk);
    chk("tail_in_ready_low", 32'(in_ready), 0);
    @(negedge clk);
    chk("tail_in_ready_back", 32'(in_ready), 1);
    @(posedge clk); #1;

    // single-row frame
    push(8'h00, 8'hA5, 8'h00, 1'b1, 1'b1, 2'd0);
    send(8'hA5, 1'b1);
    @(negedge clk);
    chk("single_out_valid", 32'(out_valid), 1);
    chk("single_in_ready", 32'(in_ready), 1);
    idle(2);

    // backpressure on a 4-row frame
    push(8'h00, 8'h40, 8'h41, 1'b1, 1'b0, 2'd0);
    push(8'h40, 8'h41, 8'h42, 1'b0, 1'b0, 2'd1);
    push(8'h41, 8'h42, 8'h43, 1'b0, 1'b0, 2'd2);
    push(8'h42, 8'h43, 8'h00, 1'b0, 1'b1, 2'd3);
    out_ready = 1'b0;
    fork
      begin
        send(8'h40, 1'b0);
        send(8'h41, 1'b0);
        send(8'h42, 1'b0);
        send(8'h43, 1'b1);
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (out_valid) begin
            seen = 1'b1;
            break;
          end
        end
        chk("bp_first_window_seen", 32'(seen), 1);
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          chk("bp_window_stable", 32'({out_prev, out_cur, out_next}), 32'h00_40_41);
          chk("bp_in_ready_low", 32'(in_ready), 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    idle(4);

    // flush mid-frame
    out_ready = 1'b0;
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    push(8'h00, 8'h01, 8'h02, 1'b1, 1'b0, 2'd0);
    push(8'h01, 8'h02, 8'h00, 1'b0, 1'b1, 2'd1);
    send(8'h01, 1'b0);
    send(8'h02, 1'b1);
    idle(3);

    // reset while a window is pending in HOLD
    out_ready = 1'b0;
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    @(negedge clk);
    chk("pre_reset_out_valid", 32'(out_valid), 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_mid_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    reset     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("reset_mid_outputs", 32'({out_prev, out_cur, out_next, out_first, out_last, out_row}), 0);
    chk("reset_mid_out_valid", 32'(out_valid), 0);
    chk("reset_mid_release_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    push(8'h00, 8'h77, 8'h88, 1'b1, 1'b0, 2'd0);
    push(8'h77, 8'h88, 8'h00, 1'b0, 1'b1, 2'd1);
    send(8'h77, 1'b0);
    send(8'h88, 1'b1);
    idle(3);

    // index wrap: 6-row frame with a 2-bit index (first follows cnt==0)
    push(8'h00, 8'h01, 8'h02, 1'b1, 1'b0, 2'd0);
    push(8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 2'd1);
    push(8'h02, 8'h03, 8'h04, 1'b0, 1'b0, 2'd2);
    push(8'h03, 8'h04, 8'h05, 1'b0, 1'b0, 2'd3);
    push(8'h04, 8'h05, 8'h06, 1'b1, 1'b0, 2'd0);
    push(8'h05, 8'h06, 8'h00, 1'b0, 1'b1, 2'd1);
    for (int i = 1; i <= 6; i++) begin
      send(8'(i), (i == 6));
    end
    idle(5);

    chk("scoreboard_drained", 32'(expq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
